// File: rtl/pre_data_fifo_if.sv
// Frame write / word read bus for pre_data_fifo; clock and reset are kept outside.
interface pre_data_fifo_if #(
  parameter int N           = 8,
  parameter int DATA_POINTS = 5,
  parameter int N_FRAMES    = 3,
  parameter int CNT_W       = 16
);
  localparam int FC_W = $clog2(N_FRAMES + 1);

  logic [N*DATA_POINTS-1:0] data_in;
  logic                     wvalid;
  logic                     wready;
  logic [N-1:0]             rd_data;
  logic                     rd_valid;
  logic                     rd_ready;
  logic                     rd_first;
  logic                     rd_last;
  logic                     empty;
  logic                     full;
  logic [FC_W-1:0]          fill_count;
  logic [CNT_W-1:0]         drop_count;

  modport slave (
    input  data_in, wvalid, rd_ready,
    output wready, rd_data, rd_valid, rd_first, rd_last, empty, full, fill_count, drop_count
  );

  modport master (
    output data_in, wvalid, rd_ready,
    input  wready, rd_data, rd_valid, rd_first, rd_last, empty, full, fill_count, drop_count
  );
endinterface

// File: rtl/pre_data_fifo.sv
// Frame FIFO: whole frames written in one cycle, streamed out one word per handshake.
module pre_data_fifo #(
  parameter int N            = 8,
  parameter int DATA_POINTS  = 5,
  parameter int N_FRAMES     = 3,
  parameter int DROP_ON_FULL = 1,
  parameter int CNT_W        = 16
) (
  input  logic             eth_clk,
  input  logic             sclr,
  pre_data_fifo_if.slave   bus
);
  localparam int FC_W  = $clog2(N_FRAMES + 1);
  localparam int PTR_W = $clog2(N_FRAMES);
  localparam int IDX_W = $clog2(DATA_POINTS);

  localparam logic [FC_W-1:0]  FULL_CNT = FC_W'(N_FRAMES);
  localparam logic [FC_W-1:0]  ONE_CNT  = FC_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_POINTS - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  typedef logic [DATA_POINTS-1:0][N-1:0] frame_t;

  frame_t           mem_q [N_FRAMES];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [FC_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [0:0]       state_q, state_d;

  logic full, wr_en, drop_en, hs, rel;

  always_comb begin
    full    = (fill_q == FULL_CNT);
    wr_en   = bus.wvalid && !full;
    drop_en = (DROP_ON_FULL != 0) && bus.wvalid && full;
    hs      = (state_q == S_STREAM) && bus.rd_ready;
    rel     = hs && (idx_q == IDX_LAST);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    fill_d   = fill_q;
    drop_d   = drop_q;
    state_d  = state_q;

    if (wr_en) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;

    if (wr_en && !rel)      fill_d = fill_q + 1'b1;
    else if (!wr_en && rel) fill_d = fill_q - 1'b1;

    if (drop_en && drop_q != '1) drop_d = drop_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (fill_q != '0) state_d = S_STREAM;
      end
      default: begin
        if (rel) begin
          idx_d    = '0;
          rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
          // A frame written this same cycle keeps the stream going with no bubble.
          if (fill_q == ONE_CNT && !wr_en) state_d = S_IDLE;
        end else if (hs) begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge eth_clk) begin
    if (sclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      idx_q    <= '0;
      fill_q   <= '0;
      drop_q   <= '0;
      state_q  <= S_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      idx_q    <= idx_d;
      fill_q   <= fill_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
    end
  end

  // Frame storage is deliberately left out of reset.
  always_ff @(posedge eth_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= frame_t'(bus.data_in);
  end

  assign bus.wready     = (DROP_ON_FULL != 0) ? 1'b1 : !full;
  assign bus.rd_valid   = (state_q == S_STREAM);
  assign bus.rd_data    = mem_q[rd_ptr_q][idx_q];
  assign bus.rd_first   = (state_q == S_STREAM) && (idx_q == '0);
  assign bus.rd_last    = (state_q == S_STREAM) && (idx_q == IDX_LAST);
  assign bus.empty      = (fill_q == '0);
  assign bus.full       = full;
  assign bus.fill_count = fill_q;
  assign bus.drop_count = drop_q;
endmodule

// File: doc/pre_data_fifo.md
PRE_DATA_FIFO -- requirements
Module: pre_data_fifo

Interface
REQ-001 Parameter N, default 8: data word width in bits.
REQ-002 Parameter DATA_POINTS, default 5: words per frame (spectrum), >= 2.
REQ-003 Parameter N_FRAMES, default 3: frame storage depth, >= 2, not restricted to powers of two.
REQ-004 Parameter DROP_ON_FULL, default 1: 1 = discard frames offered while full; 0 = backpressure the writer.
REQ-005 Parameter CNT_W, default 16: drop counter width.
REQ-006 eth_clk  in  1  sole clock; all logic is clocked on its rising edge.
REQ-007 sclr  in  1  reset, synchronous, active-high.
REQ-008 data_in  in  N*DATA_POINTS  whole frame; word k at bits [k*N +: N].
REQ-009 wvalid  in  1  data_in holds a frame to store.
REQ-010 wready  out  1  frame can be accepted this cycle.
REQ-011 rd_data  out  N  current output word.
REQ-012 rd_valid  out  1  rd_data is valid.
REQ-013 rd_ready  in  1  consumer accepts rd_data.
REQ-014 rd_first  out  1  rd_data is word 0 of a frame.
REQ-015 rd_last  out  1  rd_data is word DATA_POINTS-1 of a frame.
REQ-016 empty / full  out  1 each  fill_count == 0 / fill_count == N_FRAMES.
REQ-017 fill_count  out  $clog2(N_FRAMES+1)  frames held, including the frame being streamed.
REQ-018 drop_count  out  CNT_W  frames discarded, saturating.

Function
REQ-019 Write accept: wvalid && !full; the whole frame is stored at wr_ptr in one cycle, and wr_ptr advances, wrapping from N_FRAMES-1 to 0.
REQ-020 wready shall equal !full when DROP_ON_FULL=0, and shall be constant 1 when DROP_ON_FULL=1.
REQ-021 wvalid while full: DROP_ON_FULL=1 discards the frame, leaves storage and pointers unchanged, and increments drop_count, holding at 2^CNT_W-1. DROP_ON_FULL=0 ignores the frame and holds drop_count at 0.
REQ-022 The full flag is evaluated before a same-cycle release; there is no write-through when full.
REQ-023 Read FSM states are IDLE and STREAM.
- IDLE -> STREAM when fill_count > 0, with word_idx = 0.
- STREAM -> IDLE after the last-word handshake if no further frame is held.
REQ-024 rd_valid shall be 1 exactly in STREAM.
REQ-025 rd_data shall be word word_idx of frame rd_ptr.
REQ-026 rd_first shall be rd_valid && word_idx == 0, and rd_last shall be rd_valid && word_idx == DATA_POINTS-1.
REQ-027 Handshake rd_valid && rd_ready advances word_idx. On the last word it releases the frame: rd_ptr wraps and advances, and fill_count decrements.
REQ-028 If another frame remains after a release, including one written in the same cycle, the FSM stays in STREAM with word_idx = 0; back-to-back frames have no bubble.
REQ-029 While rd_valid && !rd_ready, rd_data, rd_first and rd_last shall hold stable.
REQ-030 Latency: a frame accepted at edge E gives fill_count = 1 after E and rd_valid = 1 after E+1 (FSM in IDLE).
REQ-031 Simultaneous accept and release: fill_count unchanged.
REQ-032 FIFO order is preserved across pointer wrap-around.

Reset
REQ-033 While sclr is high at a clock edge, the following are cleared: wr_ptr, rd_ptr, word_idx, fill_count, drop_count; state = IDLE.
REQ-034 Outputs after reset: empty=1, full=0, rd_valid=0, rd_first=0, rd_last=0, wready=1.
REQ-035 Frame storage is not cleared.
REQ-036 A reset mid-stream abandons the frame; rd_valid=0 the cycle after.

Verification
REQ-037 Parameters are N=8, DATA_POINTS=5, N_FRAMES=3. Scenario: reset; write words 0..4 = f0,0f,ee,ff,c0; rd_ready=1. Required: stream f0,0f,ee,ff,c0; rd_first with f0, rd_last with c0; fill_count 1->0; empty=1.
REQ-038 Scenario: rd_ready=0; write 3 frames; then a 4th with DROP_ON_FULL=1. Required: full=1, fill_count=3, drop_count=1, readback gives only the first 3 frames. With DROP_ON_FULL=0: wready=0 and drop_count=0.
REQ-039 Scenario: 2 frames queued, rd_ready held 1. Required: 10 consecutive rd_valid cycles; rd_last then rd_first on adjacent cycles.
REQ-040 Scenario: rd_ready toggles every cycle. Required: rd_data stable during every stall; word order 0..4 intact.
REQ-041 Scenario: fill_count=2 and a write coinciding with a last-word handshake; then 7 frames streamed through. Required: fill_count stays 2; all data is in order across pointer wrap.
REQ-042 Scenario: sclr pulse after word 2 is accepted. Required: next cycle rd_valid=0, fill_count=0, drop_count=0; the next written frame streams from word 0.
